// File: rtl/fp_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fp_pkg;

    // Operand classes produced by the unpack stage.
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Widest supported encoding (double precision); encodings are built at this
    // width and sliced down to the instance width.
    localparam int FP_MAX_W = 64;

    // Multiplier sequencer states, one cycle each except IDLE and DONE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MUL,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_DONE
    } state_t;

    // Exponent bias for a given exponent field width.
    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

    // Signed infinity: exponent all ones, fraction zero.
    function automatic logic [FP_MAX_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
        v[exp_w + man_w] = sign;
        return v;
    endfunction

    // Class from the three field predicates, independent of format width.
    function automatic fp_class_t fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero);
        if (exp_ones)      return frac_zero ? CLS_INF  : CLS_NAN;
        else if (exp_zero) return frac_zero ? CLS_ZERO : CLS_DENORM;
        else               return CLS_NORM;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit writes the final count.
    always_comb begin
        // NOTE: default assigned first so every path drives count; no latch.
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754 multiplier: one operation at a time, fixed latency,
// denormal support, round-to-nearest-even and exception flags.
module fp_mul_param
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     op_a,
    input  logic [EXP_W+MAN_W:0]     op_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     res,
    output logic [3:0]               flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;           // significand with hidden bit
    localparam int SW1  = SW + 1;
    localparam int PW   = 2 * SW;              // full product width
    localparam int XW   = EXP_W + 3;           // signed exponent, never wraps
    localparam int LZ_W = $clog2(SW + 1);
    localparam int SH_W = $clog2(MAN_W + 4);
    localparam int BIAS = fp_bias(EXP_W);

    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X = '0;
    localparam logic signed [XW-1:0] SAT_X  = XW'(MAN_W + 3);
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

    localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);
    localparam logic [FP_MAX_W-1:0] INF_FULL  = fp_inf(1'b0, EXP_W, MAN_W);
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
    localparam logic [W-2:0]        INF_MAG   = INF_FULL[W-2:0];

    state_t state_q;

    // Captured operands
    logic [W-1:0] a_q, b_q;

    // UNPACK results
    logic                 sign_q, special_q, invalid_q;
    logic [W-1:0]         special_res_q;
    logic [SW-1:0]        sig_a_q, sig_b_q;
    logic signed [XW-1:0] exp_a_q, exp_b_q;

    // MUL results
    logic [PW-1:0]        prod_q;
    logic signed [XW-1:0] exp_m_q;

    // NORM results
    logic [SW-1:0]        mant_n_q;
    logic                 g_q, r_q, s_q, tiny_q;
    logic signed [XW-1:0] exp_n_q;

    // ROUND results
    logic [MAN_W-1:0]     frac_r_q;
    logic signed [XW-1:0] exp_r_q;
    logic                 inexact_q;

    // Output registers
    logic [W-1:0] res_q;
    logic [3:0]   flags_q;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign res       = res_q;
    assign flags     = flags_q;

    // ---------------- UNPACK ----------------
    logic [EXP_W-1:0] exp_fa, exp_fb, base_a, base_b;
    logic [SW-1:0]    raw_a, raw_b;
    logic [LZ_W-1:0]  lz_a, lz_b;

    assign exp_fa = a_q[W-2:MAN_W];
    assign exp_fb = b_q[W-2:MAN_W];
    assign raw_a  = {exp_fa != '0, a_q[MAN_W-1:0]};
    assign raw_b  = {exp_fb != '0, b_q[MAN_W-1:0]};
    // A denormal's effective biased exponent is 1 before pre-normalisation.
    assign base_a = (exp_fa == '0) ? EXP_W'(1) : exp_fa;
    assign base_b = (exp_fb == '0) ? EXP_W'(1) : exp_fb;

    fp_lzc #(.WIDTH(SW), .CNT_W(LZ_W)) u_lzc_a (.value(raw_a), .count(lz_a));
    fp_lzc #(.WIDTH(SW), .CNT_W(LZ_W)) u_lzc_b (.value(raw_b), .count(lz_b));

    fp_class_t            cls_a, cls_b;
    logic                 special_d, invalid_d, sign_d;
    logic [W-1:0]         special_res_d;
    logic [SW-1:0]        sig_a_d, sig_b_d;
    logic signed [XW-1:0] exp_a_d, exp_b_d;

    // Classify operands, resolve special results and pre-normalise denormals.
    always_comb begin
        cls_a   = fp_classify(exp_fa == '0, &exp_fa, a_q[MAN_W-1:0] == '0);
        cls_b   = fp_classify(exp_fb == '0, &exp_fb, b_q[MAN_W-1:0] == '0);
        sign_d  = a_q[W-1] ^ b_q[W-1];
        sig_a_d = raw_a << lz_a;
        sig_b_d = raw_b << lz_b;
        exp_a_d = $signed({3'b000, base_a}) - $signed({{(XW-LZ_W){1'b0}}, lz_a});
        exp_b_d = $signed({3'b000, base_b}) - $signed({{(XW-LZ_W){1'b0}}, lz_b});
        special_d     = 1'b0;
        invalid_d     = 1'b0;
        special_res_d = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            special_d     = 1'b1;
            invalid_d     = 1'b1;
            special_res_d = QNAN;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            special_d     = 1'b1;
            special_res_d = {sign_d, INF_MAG};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            special_d     = 1'b1;
            special_res_d = {sign_d, {(W-1){1'b0}}};
        end
    end

    // ---------------- MUL ----------------
    logic [PW-1:0]        prod_d;
    logic signed [XW-1:0] exp_m_d;

    assign prod_d  = PW'(sig_a_q) * PW'(sig_b_q);
    assign exp_m_d = exp_a_q + exp_b_q - BIAS_X;

    // ---------------- NORM ----------------
    logic [PW-2:0]        w1, w2;
    logic                 st1, lost, tiny_d;
    logic signed [XW-1:0] e1, diff, exp_n_d;
    logic [SH_W-1:0]      shamt;

    // Bring the leading one to bit 2*MAN_W, then shift into the denormal range if needed.
    always_comb begin
        w1  = prod_q[PW-1] ? prod_q[PW-1:1] : prod_q[PW-2:0];
        st1 = prod_q[PW-1] & prod_q[0];
        e1  = prod_q[PW-1] ? exp_m_q + ONE_X : exp_m_q;
        diff    = ONE_X - e1;
        shamt   = '0;
        lost    = 1'b0;
        w2      = w1;
        tiny_d  = 1'b0;
        exp_n_d = e1;
        if (e1 <= ZERO_X) begin
            shamt   = (diff > SAT_X) ? SH_W'(MAN_W + 3) : diff[SH_W-1:0];
            w2      = w1 >> shamt;
            lost    = |(w1 & ~({(PW-1){1'b1}} << shamt));
            tiny_d  = 1'b1;
            exp_n_d = ZERO_X;
        end
    end

    // ---------------- ROUND ----------------
    logic                 inc;
    logic [SW:0]          sum;
    logic [MAN_W-1:0]     frac_r_d;
    logic signed [XW-1:0] exp_r_d;

    // Nearest-even increment with carry renormalisation.
    always_comb begin
        inc = g_q & (r_q | s_q | mant_n_q[0]);
        sum = {1'b0, mant_n_q} + SW1'(inc);
        if (sum[SW]) begin
            frac_r_d = '0;
            exp_r_d  = exp_n_q + ONE_X;
        end else begin
            frac_r_d = sum[MAN_W-1:0];
            // A denormal that rounds into the hidden bit becomes the smallest normal.
            exp_r_d  = (exp_n_q == ZERO_X && sum[MAN_W]) ? ONE_X : exp_n_q;
        end
    end

    // ---------------- PACK ----------------
    logic [W-1:0] res_d;
    logic [3:0]   flags_d;

    // Assemble the final encoding and flags.
    always_comb begin
        res_d   = '0;
        flags_d = '0;
        if (special_q) begin
            res_d                 = special_res_q;
            flags_d[FLAG_INVALID] = invalid_q;
        end else if (exp_r_q >= EMAX_X) begin
            res_d                  = {sign_q, INF_MAG};
            flags_d[FLAG_OVERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]  = 1'b1;
        end else begin
            res_d                   = {sign_q, exp_r_q[EXP_W-1:0], frac_r_q};
            flags_d[FLAG_UNDERFLOW] = tiny_q & inexact_q;
            flags_d[FLAG_INEXACT]   = inexact_q;
        end
    end

    // Sequence the fixed-latency stages and the two handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: state and datapath registers use non-blocking assignment so all
            // stages see the pre-edge values of each other.
            case (state_q)
                ST_IDLE:   if (in_valid) state_q <= ST_UNPACK;
                ST_UNPACK: state_q <= ST_MUL;
                ST_MUL:    state_q <= ST_NORM;
                ST_NORM:   state_q <= ST_ROUND;
                ST_ROUND:  state_q <= ST_PACK;
                ST_PACK:   state_q <= ST_DONE;
                ST_DONE:   if (out_ready) state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    // Load each stage register in the state that produces it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every datapath register is cleared so an aborted operation leaves no trace.
            a_q <= '0;  b_q <= '0;
            sign_q <= 1'b0;  special_q <= 1'b0;  invalid_q <= 1'b0;  special_res_q <= '0;
            sig_a_q <= '0;  sig_b_q <= '0;  exp_a_q <= '0;  exp_b_q <= '0;
            prod_q <= '0;  exp_m_q <= '0;
            mant_n_q <= '0;  g_q <= 1'b0;  r_q <= 1'b0;  s_q <= 1'b0;  tiny_q <= 1'b0;
            exp_n_q <= '0;
            frac_r_q <= '0;  exp_r_q <= '0;  inexact_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    a_q <= op_a;
                    b_q <= op_b;
                end
                ST_UNPACK: begin
                    sign_q        <= sign_d;
                    special_q     <= special_d;
                    invalid_q     <= invalid_d;
                    special_res_q <= special_res_d;
                    sig_a_q       <= sig_a_d;
                    sig_b_q       <= sig_b_d;
                    exp_a_q       <= exp_a_d;
                    exp_b_q       <= exp_b_d;
                end
                ST_MUL: begin
                    prod_q  <= prod_d;
                    exp_m_q <= exp_m_d;
                end
                ST_NORM: begin
                    mant_n_q <= w2[PW-2:MAN_W];
                    g_q      <= w2[MAN_W-1];
                    r_q      <= w2[MAN_W-2];
                    s_q      <= (|w2[MAN_W-3:0]) | st1 | lost;
                    exp_n_q  <= exp_n_d;
                    tiny_q   <= tiny_d;
                end
                ST_ROUND: begin
                    frac_r_q  <= frac_r_d;
                    exp_r_q   <= exp_r_d;
                    inexact_q <= g_q | r_q | s_q;
                end
                default: ;
            endcase
        end
    end

    // Result and flags change only on entry to DONE, so they hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q   <= '0;
            flags_q <= '0;
        end else if (state_q == ST_PACK) begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

endmodule
